cpu_mem_loader: RTL and testbench

Memory subsystem placed beside `instruction_set_model`: it supplies the CPU's instruction word (`INS_ADDR`/`INS_MEM`) and data memory (`MEM_ADDR`/`MEM_IN`/`MEM_OUT`/`MEM_CTRL`). It also contains a byte-stream program loader that fills instruction RAM while the CPU is held in reset. The CPU is released only after a complete load, and after a passing checksum when that option is compiled in.

---
 rtl/npl_cpu_pkg.sv | 12 +
 rtl/ram_1r1w.sv | 18 +
 rtl/cpu_mem_loader.sv | 112 +++++++++++
 tb/tb_cpu_mem_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/npl_cpu_pkg.sv
// npl_cpu_pkg: shared widths, memory-control constants and loader state encoding (CSUM exists only with LOADER_CHECKSUM_EN)
package npl_cpu_pkg;
  localparam int WIDTH = 32;
  localparam int ADDRSIZE = 12;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CSUM, ST_DONE} ld_state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_DONE} ld_state_t;
`endif
endpackage

// File: rtl/ram_1r1w.sv
// ram_1r1w: word array with one synchronous write port and one asynchronous read port, bit 0 is the MSB
module ram_1r1w #(
  parameter int AW = npl_cpu_pkg::ADDRSIZE,
  parameter int DW = npl_cpu_pkg::WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [0:DW-1] wdata,
  input  logic [AW-1:0] raddr,
  output logic [0:DW-1] rdata
);
  logic [0:DW-1] mem [2**AW];
  // contents are never reset so a loaded program survives a reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: CPU instruction/data RAMs plus a byte-stream program loader; LOADER_CHECKSUM_EN adds a trailer checksum
module cpu_mem_loader
  import npl_cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [7:0]          ld_data,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_err,
  output logic                cpu_rst,
  input  logic [ADDRSIZE-1:0] ins_addr,
  output logic [0:WIDTH-1]    ins_mem,
  input  logic [ADDRSIZE-1:0] mem_addr,
  input  logic [0:WIDTH-1]    mem_wdata,
  input  logic                mem_ctrl,
  output logic [0:WIDTH-1]    mem_rdata
);
  ld_state_t state, state_nx;
  logic [ADDRSIZE-1:0] n;
  logic [ADDRSIZE:0] widx;
  logic [1:0] bcnt;
  logic [WIDTH-9:0] sh;
  logic [0:WIDTH-1] word;
  logic acc, last_byte, iram_we, start, pass, loaded, loaded_nx;
  assign acc = ld_valid && ld_ready;
  assign word = {sh, ld_data};
  assign last_byte = acc && bcnt == 2'd3;
  assign iram_we = state == ST_DATA && last_byte;
  assign start = state == ST_IDLE && load_start;
  assign ld_ready = state != ST_IDLE && state != ST_DONE;
  assign ld_busy = state != ST_IDLE;
`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t ST_TAIL = ST_CSUM;
  logic [0:WIDTH-1] sum;
  logic csum_ok;
  assign pass = csum_ok;
  // running sum of data words, trailer comparison and error flag
  always_ff @(posedge clk)
    if (!rst) begin
      sum <= '0;
      csum_ok <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      if (start) begin
        sum <= '0;
        ld_err <= 1'b0;
      end
      if (iram_we) sum <= sum + word;
      if (state == ST_CSUM && last_byte) csum_ok <= word == sum;
      if (state == ST_DONE) ld_err <= !csum_ok;
    end
`else
  localparam ld_state_t ST_TAIL = ST_DONE;
  assign pass = 1'b1;
  assign ld_err = 1'b0;
`endif
  // next-state and next loaded flag
  always_comb begin
    state_nx = state;
    loaded_nx = start ? 1'b0 : state == ST_DONE ? pass : loaded;
    case (state)
      ST_IDLE:   if (load_start) state_nx = ST_CNT_HI;
      ST_CNT_HI: if (acc) state_nx = ST_CNT_LO;
      ST_CNT_LO: if (acc) state_nx = {n[ADDRSIZE-1:8], ld_data} != '0 ? ST_DATA : ST_TAIL;
      ST_DATA:   if (iram_we && widx + 1'b1 == {1'b0, n}) state_nx = ST_TAIL;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM:   if (last_byte) state_nx = ST_DONE;
`endif
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end
  // state, count capture, byte packing and status flags; cpu_rst follows the next state so it moves with it
  always_ff @(posedge clk)
    if (!rst) begin
      state <= ST_IDLE;
      n <= '0;
      widx <= '0;
      bcnt <= '0;
      sh <= '0;
      loaded <= 1'b0;
      ld_done <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state <= state_nx;
      loaded <= loaded_nx;
      cpu_rst <= !(state_nx == ST_IDLE && loaded_nx);
      if (start) begin
        widx <= '0;
        bcnt <= '0;
        ld_done <= 1'b0;
      end
      if (state == ST_DONE) ld_done <= pass;
      if (acc) sh <= {sh[WIDTH-17:0], ld_data};
      if (acc && state == ST_CNT_HI) n[ADDRSIZE-1:8] <= ld_data[ADDRSIZE-9:0];
      if (acc && state == ST_CNT_LO) n[7:0] <= ld_data;
      if (acc && state != ST_CNT_HI && state != ST_CNT_LO) bcnt <= bcnt + 2'd1;
      if (iram_we) widx <= widx + 1'b1;
    end
  ram_1r1w #(.AW(ADDRSIZE), .DW(WIDTH)) u_iram (
    .clk(clk), .we(iram_we), .waddr(widx[ADDRSIZE-1:0]), .wdata(word),
    .raddr(ins_addr), .rdata(ins_mem)
  );
  ram_1r1w #(.AW(ADDRSIZE), .DW(WIDTH)) u_dram (
    .clk(clk), .we(mem_ctrl == MEM_WRITE && !cpu_rst), .waddr(mem_addr), .wdata(mem_wdata),
    .raddr(mem_addr), .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: scoreboard bench for cpu_mem_loader, checksum cases only when LOADER_CHECKSUM_EN is defined
module tb_cpu_mem_loader;
  logic clk = 0, rst = 0, load_start = 0, ld_valid = 0, mem_ctrl = 0;
  logic [7:0] ld_data = 0;
  logic ld_ready, ld_busy, ld_done, ld_err, cpu_rst;
  logic [11:0] ins_addr = 0, mem_addr = 0;
  logic [0:31] ins_mem, mem_rdata, mem_wdata = 0;
  int tests = 0, fails = 0, cyc = 0, last_edge = 0;
  typedef struct {string name; int kind; logic [31:0] exp;} chk_t;
  typedef struct {string name; int at; bit pass;} cmp_t;
  chk_t chk_q[$];
  cmp_t cmp_q[$];
  chk_t c;
  cmp_t m;
  logic [31:0] act;
  logic [3:0] act4, exp4;
  logic [31:0] words[8];

  cpu_mem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .cpu_rst(cpu_rst),
    .ins_addr(ins_addr), .ins_mem(ins_mem), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops queued expectations and compares them against DUT outputs at the falling edge
  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      act = c.kind == 0 ? {27'd0, cpu_rst, ld_ready, ld_busy, ld_done, ld_err} : c.kind == 1 ? ins_mem : mem_rdata;
      tests++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
    if (cmp_q.size() > 0) begin
      m = cmp_q[0];
      if (cyc == m.at - 1) begin
        tests++;
        if (!(ld_busy === 1'b1 && ld_done === 1'b0 && cpu_rst === 1'b1)) begin
          fails++;
          $display("FAIL %s_pre: busy/done/cpu_rst got %b%b%b expected 101", m.name, ld_busy, ld_done, cpu_rst);
        end
      end else if (cyc == m.at) begin
        void'(cmp_q.pop_front());
        act4 = {ld_done, ld_err, cpu_rst, ld_busy};
        exp4 = {m.pass, !m.pass, !m.pass, 1'b0};
        tests++;
        if (act4 !== exp4) begin
          fails++;
          $display("FAIL %s_end: done/err/cpu_rst/busy got %b expected %b", m.name, act4, exp4);
        end
      end else if (cyc > m.at) begin
        void'(cmp_q.pop_front());
        tests++;
        fails++;
        $display("FAIL %s_late: completion check missed at cycle %0d now %0d", m.name, m.at, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int kind, input logic [31:0] exp);
    chk_q.push_back('{nm, kind, exp});
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    ld_valid = 1;
    ld_data = b;
    while (!ld_ready && t < 40) begin
      tick();
      t++;
    end
    if (!ld_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ld_ready got 0 expected 1 for byte %h", b);
    end else begin
      @(posedge clk);
      #1;
      last_edge = cyc;
    end
    ld_valid = 0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    send(b);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send_gap(w[i*8 +: 8], gap);
  endtask

  task automatic start_load();
    load_start = 1;
    tick();
    load_start = 0;
  endtask

  task automatic run_load(input string nm, input bit do_start, input int n, input int gap,
                          input logic [7:0] hi, input bit bad);
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] s = 0;
`endif
    if (do_start) start_load();
    send_gap(hi | 8'(n >> 8), gap);
    send_gap(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_word(words[i], gap);
`ifdef LOADER_CHECKSUM_EN
      s += words[i];
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(s + 32'(bad), gap);
`endif
    cmp_q.push_back('{nm, last_edge + 1, !bad});
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1;
    chk("reset_status", 0, 32'b10000);
    mem_ctrl = 1; mem_addr = 12'd5; mem_wdata = 32'h12345678;
    tick();
    mem_ctrl = 0;
    chk("reset_hold_status", 0, 32'b10000);
    words[0] = 32'h40000001; words[1] = 32'h90000000;
    run_load("load_a", 1, 2, 0, 8'h00, 0);
    chk("after_a_status", 0, 32'b00010);
    ins_addr = 0; chk("iram0_a", 1, 32'h40000001);
    ins_addr = 1; chk("iram1_a", 1, 32'h90000000);
    mem_ctrl = 1; mem_addr = 12'h00A; mem_wdata = 32'hDEADBEEF;
    tick();
    mem_addr = 12'd5; mem_wdata = 32'h11111111;
    tick();
    mem_ctrl = 0; mem_addr = 12'h00A;
    chk("dram_a", 2, 32'hDEADBEEF);
    mem_addr = 12'd5; chk("dram_5", 2, 32'h11111111);
    start_load();
    chk("restart_status", 0, 32'b11100);
    mem_ctrl = 1; mem_addr = 12'd5; mem_wdata = 32'h12345678;
    tick();
    mem_ctrl = 0;
    chk("dram_5_blocked", 2, 32'h11111111);
    words[0] = 32'hCAFEF00D; words[1] = 32'h01020304; words[2] = 32'hA5A55A5A;
    run_load("load_b", 0, 3, 1, 8'h00, 0);
    ins_addr = 0; chk("iram0_b", 1, 32'hCAFEF00D);
    ins_addr = 1; chk("iram1_b", 1, 32'h01020304);
    ins_addr = 2; chk("iram2_b", 1, 32'hA5A55A5A);
    words[0] = 32'h40000001; words[1] = 32'h90000000;
    run_load("load_c_toggle", 1, 2, 1, 8'h00, 0);
    ins_addr = 0; chk("iram0_c", 1, 32'h40000001);
    ins_addr = 1; chk("iram1_c", 1, 32'h90000000);
    ins_addr = 2; chk("iram2_kept", 1, 32'hA5A55A5A);
    start_load();
    send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
    rst = 0;
    tick();
    rst = 1;
    chk("abort_status", 0, 32'b10000);
    ins_addr = 0; chk("iram0_abort", 1, 32'h40000001);
    words[0] = 32'h77665544;
    run_load("load_hi_nibble", 1, 1, 0, 8'hF0, 0);
    chk("hi_nibble_status", 0, 32'b00010);
    ins_addr = 0; chk("iram0_d", 1, 32'h77665544);
    ins_addr = 1; chk("iram1_d", 1, 32'h90000000);
    run_load("load_empty", 1, 0, 0, 8'h00, 0);
    chk("empty_status", 0, 32'b00010);
`ifdef LOADER_CHECKSUM_EN
    words[0] = 32'h00000005;
    run_load("csum_good", 1, 1, 0, 8'h00, 0);
    chk("csum_good_status", 0, 32'b00010);
    run_load("csum_bad", 1, 1, 0, 8'h00, 1);
    chk("csum_bad_status", 0, 32'b10001);
`endif
    repeat (3) tick();
    if (cmp_q.size() != 0 || chk_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL pending: %0d checks left expected 0", cmp_q.size() + chk_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
